bias_weight_updater: RTL
========================

Name: bias_weight_updater

Overview:
Parametrised successor to the per-layer bias/weight stage. It stores the layer weight matrix and bias vector in registers and performs one SGD step per accepted transaction: w[c][p] -= lr*d[c]*a[p] and b[c] -= lr*d[c]. Work is time-multiplexed over NC columns, using NP + NC saturating Q-format multipliers. It sits between the delta-backprop stage (upstream, valid/ready) and the forward/backprop consumers of the weights (downstream, valid/ready).

Parameters:
NP, 4, previous-layer neuron count (>=1)
NC, 4, current-layer neuron count (>=1)
WI, 4, integer bits incl. sign; WD = WI+WF
WF, 4, fraction bits

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  asynchronous, active-low reset
iMode  in  1  0 = inference (no update), 1 = train; sampled only at acceptance
iLR  in  WD  learning rate, signed Q(WI.WF); sampled only at acceptance
iValid_AS  in  1  upstream valid
oReady_AS  out  1  upstream ready
iData_AS  in  NP*WD+NC*WD  a[p] at [p*WD +: WD]; d[c] at [NP*WD + c*WD +: WD]
oValid_BS  out  1  downstream valid
iReady_BS  in  1  downstream ready
oData_BS  out  NC*NP*WD+NC*WD  w[c][p] at [(c*NP+p)*WD +: WD]; b[c] at [NC*NP*WD + c*WD +: WD]

Behaviour:
- Reset (iRST=0, async): state IDLE, all w/b = 0, column counter = 0, oValid_BS = 0, oReady_AS = 0 while reset asserted. An in-flight transaction is discarded.
- FSM states: IDLE, SCALE, UPDATE, HOLD.
- oReady_AS = (state==IDLE) && iRST. Transfer occurs when iValid_AS && oReady_AS at the clock edge.
- IDLE: on transfer, latch a[], d[], iLR, iMode. If iMode=0, go to HOLD; otherwise go to SCALE.
- SCALE (1 cycle): g[c] = mulq(lr, d[c]) for all c, registered. Go to UPDATE with counter = 0.
- UPDATE (NC cycles): for column c = counter, w[c][p] <= subs(w[c][p], mulq(g[c], a[p])) for all p, and b[c] <= subs(b[c], g[c]). The counter increments each cycle. After c = NC-1, go to HOLD.
- HOLD: oValid_BS = 1. On iReady_BS=1, go to IDLE. oReady_AS = 0 throughout HOLD, so there is one idle bubble between transactions.
- Latency, counted as edges from transfer to oValid_BS high: inference = 1; train = NC+2.
- oData_BS is driven directly from the storage registers. It is valid and stable whenever oValid_BS=1 and does not change while stalled.
- mulq(x,y): full 2WD-bit signed product, arithmetic shift right by WF (floor), then saturate to [-2^(WD-1), 2^(WD-1)-1].
- subs(x,y): computed at WD+1 bits, then saturated to WD bits.
- Upstream iValid_AS/iData_AS activity outside IDLE is ignored. Data is not consumed until ready.
- Counter width is max(1, $clog2(NC)). NC=1 gives a single UPDATE cycle.

Optional Feature:
- Macro: BIAS_WEIGHT_ROUND_EN.
- Defined: mulq adds 2^(WF-1) before the shift (round half up, toward +inf), then saturates.
- Undefined: floor truncation as described above.
- Applies to every mulq instance. Latency is unchanged.

Decomposition:
- Shared package bw_pkg holds:
  - WD derivation
  - state encoding (IDLE/SCALE/UPDATE/HOLD)
  - saturation bounds
  - sat and subs functions
- One sub-module, fxp_mul_sat: signed Q multiply, shift, optional round, saturate, purely combinational.
  - Instantiated NC times for SCALE and NP times for UPDATE.

Test Plan (WI=4, WF=4, WD=8, NP=NC=4):
1. Basic train: lr=0x10, all a=0x10, all d=0x08 -> oValid_BS exactly 6 edges after transfer; all w=0xF8, all b=0xF8.
2. Saturation: lr=0x70, d=0x70, a=0x70 -> g=0x7F, w=0x81. Second identical transaction -> w=0x80, b=0x80 (clamped, no wrap).
3. Rounding (lr=0x01, d[0]=0x08 then separately d[0]=0xF8):
   - Without macro: b[0]=0x00, then 0x01.
   - With BIAS_WEIGHT_ROUND_EN: b[0]=0xFF, then 0x00.
4. Inference: iMode=0 after test 1 -> oValid_BS 1 edge after transfer; w/b unchanged (0xF8).
5. Backpressure: iReady_BS=0 for 5 cycles in HOLD -> oValid_BS held high, oData_BS stable, oReady_AS=0; an iValid_AS pulse in this window is not accepted.
6. Reset mid-UPDATE: assert iRST=0 at counter=2 -> oValid_BS=0 immediately and all w/b=0. After release, oReady_AS=1 and the next transaction behaves as in test 1.

Source files
------------

// File: rtl/bias_weight_updater_pkg.sv
// Shared definitions for the bias/weight updater: word width, FSM encoding and
// saturating arithmetic helpers evaluated on a wide signed carrier.
package bw_pkg;

    localparam int WI_DEFAULT = 4;
    localparam int WF_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCALE,
        UPDATE,
        HOLD
    } stateT;

    function automatic int calcWd(input int wi, input int wf);
        return wi + wf;
    endfunction

    function automatic logic signed [63:0] satMax(input int wd);
        return (64'sd1 <<< (wd - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] satMin(input int wd);
        return -(64'sd1 <<< (wd - 1));
    endfunction

    // Clamp a wide signed value into the range of a wd-bit signed word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int wd);
        if (x > satMax(wd)) return satMax(wd);
        else if (x < satMin(wd)) return satMin(wd);
        else return x;
    endfunction

    function automatic logic signed [63:0] subs(input logic signed [63:0] x,
                                                input logic signed [63:0] y,
                                                input int wd);
        return sat(x - y, wd);
    endfunction

endpackage

// File: rtl/bias_weight_updater_fxp_mul_sat.sv
// Combinational signed Q(WI.WF) multiply: full product, shift by WF, saturate.
// Define BIAS_WEIGHT_ROUND_EN to round half up before the shift instead of flooring.
module fxp_mul_sat
    import bw_pkg::*;
#(
    parameter int WI = WI_DEFAULT,
    parameter int WF = WF_DEFAULT,
    localparam int WD = calcWd(WI, WF)
) (
    input  logic [WD-1:0] iA,
    input  logic [WD-1:0] iB,
    output logic [WD-1:0] oP
);

    localparam logic [2*WD:0] HALF_LSB = ({{(2*WD){1'b0}}, 1'b1} << WF) >> 1;

    logic signed [2*WD-1:0] prod;
    logic signed [2*WD:0]   biased;
    logic signed [2*WD:0]   shifted;

    assign prod = (2*WD)'(signed'(iA)) * (2*WD)'(signed'(iB));

`ifdef BIAS_WEIGHT_ROUND_EN
    // One extra bit keeps the rounding add from overflowing the product.
    assign biased = (2*WD+1)'(prod) + signed'(HALF_LSB);
`else
    assign biased = (2*WD+1)'(prod);
`endif

    assign shifted = biased >>> WF;
    assign oP      = WD'(sat(64'(shifted), WD));

endmodule

// File: rtl/bias_weight_updater.sv
// One SGD step per accepted transaction on a register-held weight matrix and bias
// vector, one column per cycle. Rounding mode selected by BIAS_WEIGHT_ROUND_EN.
module bias_weight_updater
    import bw_pkg::*;
#(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WI = WI_DEFAULT,
    parameter int WF = WF_DEFAULT,
    localparam int WD = calcWd(WI, WF)
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iMode,
    input  logic [WD-1:0]                iLR,
    input  logic                         iValid_AS,
    output logic                         oReady_AS,
    input  logic [NP*WD+NC*WD-1:0]       iData_AS,
    output logic                         oValid_BS,
    input  logic                         iReady_BS,
    output logic [NC*NP*WD+NC*WD-1:0]    oData_BS
);

    localparam int            CW       = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(NC - 1);

    stateT         state, nextState;
    logic [CW-1:0] counter;
    logic          transfer;
    logic [WD-1:0] lrReg;
    logic [WD-1:0] aReg  [NP];
    logic [WD-1:0] dReg  [NC];
    logic [WD-1:0] g     [NC];
    logic [WD-1:0] gNext [NC];
    logic [WD-1:0] prod  [NP];
    logic [WD-1:0] w     [NC][NP];
    logic [WD-1:0] b     [NC];
    logic [WD-1:0] gSel;

    function automatic logic [WD-1:0] subW(input logic [WD-1:0] x, input logic [WD-1:0] y);
        return WD'(subs(64'(signed'(x)), 64'(signed'(y)), WD));
    endfunction

    for (genvar c = 0; c < NC; c++) begin : gScale
        fxp_mul_sat #(.WI(WI), .WF(WF)) uMul (.iA(lrReg), .iB(dReg[c]), .oP(gNext[c]));
    end

    for (genvar p = 0; p < NP; p++) begin : gUpdate
        fxp_mul_sat #(.WI(WI), .WF(WF)) uMul (.iA(gSel), .iB(aReg[p]), .oP(prod[p]));
    end

    always_comb begin
        gSel = '0;
        for (int c = 0; c < NC; c++)
            if (counter == CW'(c)) gSel = g[c];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= IDLE;
        else       state <= nextState;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        nextState = state;
        oReady_AS = 1'b0;
        oValid_BS = 1'b0;
        case (state)
            IDLE: begin
                oReady_AS = iRST;
                if (iValid_AS && iRST) nextState = iMode ? SCALE : HOLD;
            end
            SCALE:  nextState = UPDATE;
            UPDATE: if (counter == LAST_COL) nextState = HOLD;
            HOLD: begin
                oValid_BS = 1'b1;
                if (iReady_BS) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign transfer = iValid_AS && oReady_AS;

    // NOTE: weights and biases are architecturally visible on oData_BS, so the
    // whole storage array is cleared by reset rather than left undefined.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            counter <= '0;
            lrReg   <= '0;
            for (int p = 0; p < NP; p++) aReg[p] <= '0;
            for (int c = 0; c < NC; c++) begin
                dReg[c] <= '0;
                g[c]    <= '0;
                b[c]    <= '0;
                for (int p = 0; p < NP; p++) w[c][p] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (transfer) begin
                    lrReg <= iLR;
                    for (int p = 0; p < NP; p++) aReg[p] <= iData_AS[p*WD +: WD];
                    for (int c = 0; c < NC; c++) dReg[c] <= iData_AS[NP*WD + c*WD +: WD];
                end
                SCALE: begin
                    for (int c = 0; c < NC; c++) g[c] <= gNext[c];
                    counter <= '0;
                end
                UPDATE: begin
                    for (int c = 0; c < NC; c++) begin
                        if (counter == CW'(c)) begin
                            for (int p = 0; p < NP; p++) w[c][p] <= subW(w[c][p], prod[p]);
                            b[c] <= subW(b[c], g[c]);
                        end
                    end
                    counter <= counter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        oData_BS = '0;
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < NP; p++) oData_BS[(c*NP + p)*WD +: WD] = w[c][p];
            oData_BS[NC*NP*WD + c*WD +: WD] = b[c];
        end
    end

endmodule
